// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response UART transmitter.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    START,
    DATA,
    STOP,
    FIN
  } puf_state_e;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned FRAME_BITS           = 10;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/puf_resp_uart_tx_uart_byte_tx.sv
// 8N1 byte serialiser; accepts a new byte during the last stop-bit cycle so
// back-to-back frames leave no idle gap on the line.
module uart_byte_tx
  import puf_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  puf_state_e        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  assign bit_end    = (baud_q == BAUD_LAST);
  assign byte_ready = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign tx         = tx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (byte_valid) begin
          state_d = START;
          sh_d    = byte_in;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_valid) begin
            state_d = START;
            sh_d    = byte_in;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/puf_resp_uart_tx.sv
// PUF measurement initiator: requests a measurement, captures the response
// word and streams it LSB byte first as back-to-back 8N1 UART frames.
module puf_resp_uart_tx
  import puf_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned RESP_BITS    = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trigger,
  input  logic                 puf_done,
  input  logic [RESP_BITS-1:0] response,
  output logic                 puf_start,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned NUM_BYTES = RESP_BITS / 8;
  localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  puf_state_e           state_q, state_d;
  logic [RESP_BITS-1:0] cap_q, cap_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d, next_idx;
  logic                 puf_start_q, busy_q, tx_done_q;
  logic [7:0]           byte_in;
  logic                 byte_valid, byte_ready;

  assign next_idx  = byte_idx_q + 1'b1;
  assign puf_start = puf_start_q;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .tx        (tx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      byte_idx_q  <= '0;
      puf_start_q <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      byte_idx_q  <= byte_idx_d;
      puf_start_q <= (state_d == REQ);
      busy_q      <= (state_d != IDLE);
      tx_done_q   <= (state_d == FIN);
    end
  end

  // byte_idx tracks the byte on the line; DATA here spans the serialiser's
  // START/DATA/STOP, and byte 0 is taken straight from response so its start
  // bit appears the cycle after puf_done.
  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    byte_idx_d = byte_idx_q;
    byte_valid = 1'b0;
    byte_in    = cap_q[{next_idx, 3'b000} +: 8];
    unique case (state_q)
      IDLE: begin
        if (trigger) state_d = REQ;
      end
      REQ: begin
        byte_in    = response[7:0];
        byte_valid = puf_done;
        if (puf_done) begin
          cap_d      = response;
          byte_idx_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (byte_idx_q != LAST_IDX) begin
          byte_valid = 1'b1;
          if (byte_ready) byte_idx_d = next_idx;
        end else if (byte_ready) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/puf_resp_uart_tx.md
Name: puf_resp_uart_tx

Overview:
Host-side initiator and transmitter for the PUF measurement cycle. On a `trigger` pulse it raises `puf_start` to the measurement controller and holds it until `puf_done`. It then captures the full response word and releases `puf_start` so the controller can return to idle. It serialises the captured response off-chip as 8N1 UART frames.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range ≥2.
RESP_BITS, 256, response width; must be a multiple of 8.
NUM_BYTES, RESP_BITS/8, derived value; not overridable.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
trigger  in  1  request one measurement-plus-transmit; single-cycle pulse or level
puf_done  in  1  measurement complete; single-cycle pulse from the controller
response  in  RESP_BITS  shift-register contents; valid in the cycle `puf_done`=1
puf_start  out  1  measurement request to the controller
tx  out  1  UART serial line; idle high
busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse after the last stop bit

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low (`rst_n`), sampled on posedge `clk`.
- Reset values: state=IDLE, puf_start=0, tx=1, busy=0, tx_done=0. All counters are 0 and the capture register is 0.
- Reset mid-operation: on the next edge `tx` returns to 1 and `puf_start` to 0, and the frame in progress is abandoned. No tx_done is issued.
- All outputs are registered.
- IDLE:
  - If trigger=1, go to REQ; `puf_start`=1 from the next cycle.
  - Otherwise stay in IDLE.
- REQ:
  - Hold puf_start=1 and wait for `puf_done`. There is no timeout.
  - In the cycle puf_done=1, latch `response` into `cap_q`, load byte_idx=0, and go to START.
  - puf_start=0 from the next cycle.
- Capture: changes on `response` after capture have no effect on the output.
- START: tx=0 for CLKS_PER_BIT cycles. Load the shift byte with cap_q[8*byte_idx +: 8].
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - bit_idx counts 0..7; leave after bit 7's last cycle.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If byte_idx == NUM_BYTES-1, go to FIN.
  - Otherwise byte_idx+1 and go to START. There is no idle gap between frames.
- FIN: tx_done=1 for exactly one cycle, then go to IDLE.
- Byte order: byte 0 = response[7:0] is sent first; byte NUM_BYTES-1 = response[RESP_BITS-1 -: 8] is sent last.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
- byte_idx width: $clog2(NUM_BYTES).
- trigger outside IDLE: ignored, not queued.
- puf_done outside REQ: ignored.
- trigger and puf_done high together in IDLE: only the trigger acts.
- Total line time from first start bit to tx_done: NUM_BYTES*10*CLKS_PER_BIT cycles. tx_done rises one cycle after the last stop-bit cycle.

Decomposition:
- Shared package (`puf_pkg`):
  - State encoding enum: IDLE, REQ, START, DATA, STOP, FIN.
  - UART constants: DATA_BITS=8, FRAME_BITS=10.
  - Default CLKS_PER_BIT.
- Sub-module `uart_byte_tx`:
  - Ports: clk, rst_n, byte_in, byte_valid, byte_ready, tx.
  - Contains the baud counter and START/DATA/STOP sequencing.
  - The top holds the REQ handshake, the capture register and byte_idx sequencing, and feeds `uart_byte_tx` through the valid/ready pair.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and RESP_BITS=256.
1. rst_n=0 for 3 cycles with trigger=1 -> tx=1, puf_start=0, busy=0 throughout. No state change after release until a fresh trigger.
2. trigger pulse at cycle T -> puf_start=1 from T+1 and busy=1. With puf_done first asserted at T+20, puf_start=0 from T+21.
3. Capture and first frame: response=256'h...00A5, puf_done pulse -> first frame tx sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles. Byte 1 (response[15:8]) follows with no gap.
4. Full response = 32 bytes 8'h00..8'h1F -> UART monitor decodes 0x00..0x1F in order. tx_done is one cycle, 1281 cycles after puf_done. busy=0 the cycle after tx_done.
5. trigger pulsed during DATA of byte 5, and `response` changed after capture -> neither affects the output. No second puf_start assertion; decoded stream matches the captured value.
6. rst_n=0 for one cycle mid-byte 10 -> tx=1 and busy=0 next cycle, tx_done never pulses. A following trigger restarts cleanly from byte 0.
